pause_ctrl: RTL and testbench
=============================

# pause_ctrl

Pause controller for the Space Invaders display path; sits directly upstream of the pause-symbol overlay and drives its `pause_active` input. Synchronises and debounces the raw pause push-button and toggles between running and paused. The game freezes and resumes only on frame boundaries so no partially updated frame is ever drawn. It also produces the game-logic enable and, optionally, a blinking overlay request.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000, clock cycles the synchronised button must be stable before its level is accepted (10 ms at 100 MHz); minimum 2
- `BLINK_FRAMES`, 30, frames per blink half-period while paused (used only with `PAUSE_BLINK_EN`); minimum 1
- `clk`  input  1  system clock; all logic on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `btn_pause`  input  1  raw, asynchronous push-button, 1 = pressed
- `frame_tick`  input  1  one-cycle pulse at start of vertical blank, from VGA sync
- `game_over`  input  1  level; while high, pausing is disabled
- `pause_active`  output  1  overlay request to pause symbol
- `paused`  output  1  steady paused-state flag, never blinks
- `game_enable`  output  1  1 = game logic may advance
- `pause_toggled`  output  1  one-cycle pulse on each accepted state change (entering PAUSED or RUNNING)

## Operation
- Input path: 2-FF synchroniser on `btn_pause` -> debounce counter -> debounced level `btn_db` -> rising-edge detect -> one-cycle `press`.
- Debounce: counter clears whenever synchronised level differs from `btn_db`; when it equals `DEBOUNCE_CYCLES-1` with the level still different, `btn_db` takes the new level and the counter clears. Counter width `$clog2(DEBOUNCE_CYCLES)`; never wraps.
- FSM states: RUNNING, PAUSE_PEND, PAUSED, RESUME_PEND.
  - RUNNING: `press` -> PAUSE_PEND.
  - PAUSE_PEND: `frame_tick` -> PAUSED.
  - PAUSED: `press` -> RESUME_PEND.
  - RESUME_PEND: `frame_tick` -> RUNNING.
- `press` in either pending state is ignored; no cancel and no queueing.
- A `frame_tick` in the same cycle as the `press` that enters a pending state is not consumed; the transition waits for the next tick.
- `game_over` high: FSM forced to RUNNING on the next edge from any state, `press` ignored, no `pause_toggled`.
- `paused` = 1 in PAUSED and RESUME_PEND.
- `game_enable` = 1 in RUNNING and PAUSE_PEND.
- `pause_toggled` pulses in the cycle after entering PAUSED or RUNNING from a pending state.
- `pause_active` = `paused`, gated by the blink phase when `PAUSE_BLINK_EN` is defined.
- All outputs registered.

## Timing
- Reset values: state RUNNING, `btn_db`=0, counters 0, `pause_active`=0, `paused`=0, `game_enable`=1, `pause_toggled`=0, blink phase 1.
- Button latency: 2 cycles synchroniser + `DEBOUNCE_CYCLES` stable cycles + 1 cycle edge detect before `press`; FSM moves on the edge after `press`.
- Pause latency: outputs change one cycle after the consuming `frame_tick`; worst case one full frame after `press`.
- Bounces shorter than `DEBOUNCE_CYCLES` produce no `press`; a held button produces exactly one `press`; release produces none.
- `reset` asserted mid-debounce or mid-pending: immediate return to reset values; no stale `press` after release of reset.

## Configuration
- `PAUSE_BLINK_EN` defined:
  - Frame counter, width `$clog2(BLINK_FRAMES+1)`, counts `frame_tick` while in PAUSED or RESUME_PEND.
  - After `BLINK_FRAMES` ticks the blink phase toggles and the counter clears.
  - Phase is set to 1 and the counter cleared on entry to PAUSED.
  - `pause_active` = `paused` AND phase.
- `PAUSE_BLINK_EN` not defined: no blink counter; `pause_active` = `paused` (steady).

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `BLINK_FRAMES`=2.
- Reset then idle 20 cycles -> `game_enable`=1, `paused`=0, `pause_active`=0, `pause_toggled` never high.
- Button high 3 cycles, low, repeated 5 times -> no `press`, state stays RUNNING.
- Button held high 50 cycles, `frame_tick` every 16 cycles -> exactly one transition; `paused`=1 and `game_enable`=0 one cycle after the first tick following `press`; one `pause_toggled`.
- Second clean press while PAUSED, extra press during RESUME_PEND -> returns to RUNNING on the next `frame_tick`; the extra press is ignored; total of 2 `pause_toggled` pulses.
- `game_over`=1 while PAUSED -> RUNNING next edge, `game_enable`=1; presses during `game_over` produce no change.
- Blink build, paused across 6 frame ticks -> `pause_active` pattern 1,1,0,0,1,1 per frame.
- Non-blink build, same stimulus -> `pause_active` constant 1.

Source files
------------

// File: rtl/pause_ctrl.sv
// pause_ctrl: debounced pause button and frame-aligned RUNNING/PAUSED controller for the display path.
// Optional feature macro: PAUSE_BLINK_EN (blinks pause_active while paused; default build is steady).
module pause_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic frame_tick,
  input  logic game_over,
  output logic pause_active,
  output logic paused,
  output logic game_enable,
  output logic pause_toggled
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("pause_ctrl: need DEBOUNCE_CYCLES >= 2 and BLINK_FRAMES >= 1");
  end

  typedef enum logic [1:0] {
    RUNNING,
    PAUSE_PEND,
    PAUSED,
    RESUME_PEND
  } state_t;

  logic             sync1_q, sync2_q;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             db_prev_q;
  logic             press_q;
  state_t           state_q;
  logic             paused_q, game_enable_q, pause_toggled_q, pause_active_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_pause;
      sync2_q <= sync1_q;
    end
  end

  // The counter only runs while the synchronised level disagrees with btn_db, so it never wraps.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q  <= 1'b0;
      db_cnt_q  <= '0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      btn_db_q  <= btn_db_d;
      db_cnt_q  <= db_cnt_d;
      db_prev_q <= btn_db_q;
      press_q   <= btn_db_q & ~db_prev_q;
    end
  end

`ifdef PAUSE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic               phase_q, phase_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  // Blink advance for one paused cycle; only committed by the FSM while paused.
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d     = ~phase_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUNNING;
      paused_q        <= 1'b0;
      game_enable_q   <= 1'b1;
      pause_toggled_q <= 1'b0;
      pause_active_q  <= 1'b0;
`ifdef PAUSE_BLINK_EN
      phase_q         <= 1'b1;
      blink_cnt_q     <= '0;
`endif
    end else begin
      pause_toggled_q <= 1'b0;
      if (game_over) begin
        state_q        <= RUNNING;
        paused_q       <= 1'b0;
        game_enable_q  <= 1'b1;
        pause_active_q <= 1'b0;
      end else begin
        case (state_q)
          RUNNING: begin
            if (press_q) state_q <= PAUSE_PEND;
          end
          // A tick in the same cycle as the entering press was seen in RUNNING, so it is not consumed.
          PAUSE_PEND: begin
            if (frame_tick) begin
              state_q         <= PAUSED;
              paused_q        <= 1'b1;
              game_enable_q   <= 1'b0;
              pause_toggled_q <= 1'b1;
              pause_active_q  <= 1'b1;
`ifdef PAUSE_BLINK_EN
              phase_q         <= 1'b1;
              blink_cnt_q     <= '0;
`endif
            end
          end
          PAUSED: begin
            if (press_q) state_q <= RESUME_PEND;
`ifdef PAUSE_BLINK_EN
            phase_q        <= phase_d;
            blink_cnt_q    <= blink_cnt_d;
            pause_active_q <= phase_d;
`endif
          end
          RESUME_PEND: begin
            if (frame_tick) begin
              state_q         <= RUNNING;
              paused_q        <= 1'b0;
              game_enable_q   <= 1'b1;
              pause_toggled_q <= 1'b1;
              pause_active_q  <= 1'b0;
            end else begin
`ifdef PAUSE_BLINK_EN
              phase_q        <= phase_d;
              blink_cnt_q    <= blink_cnt_d;
              pause_active_q <= phase_d;
`endif
            end
          end
          default: begin
            state_q        <= RUNNING;
            paused_q       <= 1'b0;
            game_enable_q  <= 1'b1;
            pause_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pause_active  = pause_active_q;
  assign paused        = paused_q;
  assign game_enable   = game_enable_q;
  assign pause_toggled = pause_toggled_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// tb_pause_ctrl: directed checks of pause_ctrl with DEBOUNCE_CYCLES=4, BLINK_FRAMES=2.
// Inputs change on the falling edge; outputs are observed on the falling edge after each rising edge.
module tb_pause_ctrl;

  logic clk = 1'b0;
  logic reset, btn_pause, frame_tick, game_over;
  logic pause_active, paused, game_enable, pause_toggled;

  int vectors     = 0;
  int miscompares = 0;
  int tog_cnt     = 0;
  logic exp_pa [6];

  always #5 clk = ~clk;

  pause_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_pause    (btn_pause),
    .frame_tick   (frame_tick),
    .game_over    (game_over),
    .pause_active (pause_active),
    .paused       (paused),
    .game_enable  (game_enable),
    .pause_toggled(pause_toggled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (pause_toggled) tog_cnt++;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  // Long enough for a press to be accepted, then long enough for the release to settle.
  task automatic press_clean();
    btn_pause = 1'b1;
    step(12);
    btn_pause = 1'b0;
    step(8);
  endtask

  initial begin
`ifdef PAUSE_BLINK_EN
    exp_pa = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_pa = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    reset      = 1'b1;
    btn_pause  = 1'b0;
    frame_tick = 1'b0;
    game_over  = 1'b0;
    @(negedge clk);
    step(3);
    check("rst_game_enable", game_enable, 1);
    check("rst_paused", paused, 0);
    check("rst_pause_active", pause_active, 0);
    check("rst_pause_toggled", pause_toggled, 0);

    reset   = 1'b0;
    tog_cnt = 0;
    step(20);
    check("idle_game_enable", game_enable, 1);
    check("idle_paused", paused, 0);
    check("idle_pause_active", pause_active, 0);
    check("idle_toggles", tog_cnt, 0);

    // Bounces one cycle too short to be accepted.
    repeat (5) begin
      btn_pause = 1'b1;
      step(3);
      btn_pause = 1'b0;
      step(2);
    end
    step(4);
    tick();
    step(10);
    tick();
    step(2);
    check("bounce_game_enable", game_enable, 1);
    check("bounce_paused", paused, 0);
    check("bounce_toggles", tog_cnt, 0);

    // Held button: press lands after cycle 6, first usable tick is cycle 15.
    for (int i = 0; i < 50; i++) begin
      btn_pause  = 1'b1;
      frame_tick = ((i % 16) == 15);
      step(1);
      if (i == 14) begin
        check("held_pend_paused", paused, 0);
        check("held_pend_game_enable", game_enable, 1);
      end
      if (i == 15) begin
        check("held_paused", paused, 1);
        check("held_game_enable", game_enable, 0);
        check("held_pulse", pause_toggled, 1);
        check("held_pause_active", pause_active, 1);
      end
    end
    frame_tick = 1'b0;
    check("held_toggles", tog_cnt, 1);
    btn_pause = 1'b0;
    step(10);
    check("release_paused", paused, 1);

    // Resume press, then an extra press while still pending.
    press_clean();
    check("resume_pend_paused", paused, 1);
    check("resume_pend_game_enable", game_enable, 0);
    press_clean();
    check("extra_pend_paused", paused, 1);
    tick();
    check("resume_paused", paused, 0);
    check("resume_game_enable", game_enable, 1);
    check("resume_pulse", pause_toggled, 1);
    check("resume_pause_active", pause_active, 0);
    check("resume_toggles", tog_cnt, 2);
    step(4);
    tick();
    step(2);
    check("no_queue_game_enable", game_enable, 1);
    check("no_queue_toggles", tog_cnt, 2);

    // game_over forces RUNNING and masks presses.
    press_clean();
    tick();
    check("go_pre_paused", paused, 1);
    check("go_pre_toggles", tog_cnt, 3);
    game_over = 1'b1;
    step(1);
    check("go_paused", paused, 0);
    check("go_game_enable", game_enable, 1);
    check("go_pulse", pause_toggled, 0);
    check("go_pause_active", pause_active, 0);
    press_clean();
    tick();
    step(2);
    check("go_press_paused", paused, 0);
    check("go_press_game_enable", game_enable, 1);
    check("go_toggles", tog_cnt, 3);
    game_over = 1'b0;
    step(2);
    tick();
    step(2);
    check("go_after_paused", paused, 0);
    check("go_after_game_enable", game_enable, 1);

    // Six frames of pause: blink pattern or steady overlay.
    press_clean();
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("blink_pa_%0d", k), pause_active, exp_pa[k]);
      check($sformatf("blink_paused_%0d", k), paused, 1);
      step(3);
    end

    // Asynchronous reset mid-debounce while paused.
    btn_pause = 1'b1;
    step(4);
    check("pre_rst_paused", paused, 1);
    reset     = 1'b1;
    btn_pause = 1'b0;
    #1;
    check("async_rst_paused", paused, 0);
    check("async_rst_game_enable", game_enable, 1);
    check("async_rst_pause_active", pause_active, 0);
    step(2);
    reset   = 1'b0;
    tog_cnt = 0;
    step(10);
    tick();
    step(2);
    check("post_rst_paused", paused, 0);
    check("post_rst_game_enable", game_enable, 1);
    check("post_rst_toggles", tog_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
